// File: rtl/lcb_rx_framer.sv
// lcb_rx_framer: groups LCB reply bytes from the UART receiver into frames.
// A frame ends after GAP_CYCLES of line silence. Accepted bytes are written
// to the 32x8 reply buffer. On frame close the block reports the frame length
// and an error flag to the read-side commutator.
// Optional feature: define LCB_RX_CSUM_EN to check that the final byte of a
// frame is the modulo-256 sum of the bytes before it.
`timescale 1ns/1ps
module lcb_rx_framer #(
   parameter int unsigned BYTES      = 4,
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned GAP_CYCLES = 400
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iValid,
   input  logic [7:0] iData,
   output logic [7:0] oWrData,
   output logic [4:0] oWrAdr,
   output logic       oWE,
   output logic       oDone,
   output logic [5:0] oLen,
   output logic       oErr,
   output logic       oBusy
);
   localparam int unsigned CNT_W = 6;
   localparam int unsigned ADR_W = 5;
   localparam int unsigned GAP_W = $clog2(GAP_CYCLES);

   typedef enum logic [1:0] {IDLE, RECV, CLOSE} state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [GAP_W-1:0] gap;
   logic             ovf;
   logic             csumErr_c;

`ifdef LCB_RX_CSUM_EN
   logic [7:0] sum;
   logic [7:0] lastByte;

   // Running sum of every accepted byte except the newest, which is held aside
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum      <= 8'h00;
         lastByte <= 8'h00;
      end else if (iValid && (state != RECV)) begin
         sum      <= 8'h00;
         lastByte <= iData;
      end else if (iValid && (count < CNT_W'(DEPTH))) begin
         sum      <= sum + lastByte;
         lastByte <= iData;
      end
   end

   assign csumErr_c = (count < CNT_W'(2)) || (lastByte != sum);
`else
   assign csumErr_c = 1'b0;
`endif

   // Frame FSM: byte capture, silence timing, frame close reporting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         count   <= '0;
         gap     <= '0;
         ovf     <= 1'b0;
         oWrData <= 8'h00;
         oWrAdr  <= '0;
         oWE     <= 1'b0;
         oDone   <= 1'b0;
         oLen    <= '0;
         oErr    <= 1'b0;
         oBusy   <= 1'b0;
      end else begin
         oWE   <= 1'b0;
         oDone <= 1'b0;
         case (state)
            IDLE, CLOSE: begin
               if (state == CLOSE) begin
                  oDone <= 1'b1;
                  oLen  <= count;
                  oErr  <= (count != CNT_W'(BYTES)) | ovf | csumErr_c;
                  ovf   <= 1'b0;
                  count <= '0;
                  gap   <= '0;
               end
               // A byte arriving on the close cycle opens the next frame directly
               if (iValid) begin
                  oWE     <= 1'b1;
                  oWrAdr  <= '0;
                  oWrData <= iData;
                  count   <= CNT_W'(1);
                  gap     <= '0;
                  oBusy   <= 1'b1;
                  state   <= RECV;
               end else begin
                  oBusy <= 1'b0;
                  state <= IDLE;
               end
            end
            RECV: begin
               if (iValid) begin
                  gap <= '0;
                  if (count < CNT_W'(DEPTH)) begin
                     oWE     <= 1'b1;
                     oWrAdr  <= count[ADR_W-1:0];
                     oWrData <= iData;
                     count   <= count + CNT_W'(1);
                  end else begin
                     ovf <= 1'b1;
                  end
               end else if (gap == GAP_W'(GAP_CYCLES - 1)) begin
                  oBusy <= 1'b0;
                  state <= CLOSE;
               end else begin
                  gap <= gap + GAP_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lcb_rx_framer.sv
// Randomized bench for lcb_rx_framer. Stimulus is a per-cycle list of
// (valid, data) entries. The reference groups byte arrival times into frames
// by the silence rule and derives the expected writes, close events, held
// length/error and busy windows from them.
`timescale 1ns/1ps
module tb_lcb_rx_framer;
   localparam int GAP   = 400;
   localparam int DEPTH = 32;
   localparam int BYTES = 4;

   typedef struct {int cyc; int adr; int dat;} wr_t;
   typedef struct {int cyc; int len; int err;} done_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       iValid = 1'b0;
   logic [7:0] iData = 8'h00;
   logic [7:0] oWrData;
   logic [4:0] oWrAdr;
   logic       oWE, oDone, oErr, oBusy;
   logic [5:0] oLen;

   int nChecks = 0;
   int nFails  = 0;
   int curLen  = 0;
   int curErr  = 0;

   bit         sVld[$];
   logic [7:0] sDat[$];

   lcb_rx_framer dut (
      .clk(clk), .rst(rst), .iValid(iValid), .iData(iData),
      .oWrData(oWrData), .oWrAdr(oWrAdr), .oWE(oWE), .oDone(oDone),
      .oLen(oLen), .oErr(oErr), .oBusy(oBusy)
   );

   always #6 clk = ~clk;

   initial begin
      #10ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic addIdle(input int n);
      for (int i = 0; i < n; i++) begin
         sVld.push_back(1'b0);
         sDat.push_back(8'($urandom));
      end
   endtask

   task automatic addByte(input logic [7:0] d);
      sVld.push_back(1'b1);
      sDat.push_back(d);
   endtask

   // Bytes of a frame spaced 'space' cycles apart, first one immediately
   task automatic addFrame(input int nb, input int space, input logic [7:0] first, input logic [7:0] step);
      logic [7:0] b;
      b = first;
      for (int k = 0; k < nb; k++) begin
         if (k > 0) addIdle(space - 1);
         addByte(b);
         b = b + step;
      end
   endtask

   task automatic addRandomFrames(input int nFrames);
      int lens[10];
      int gaps[4];
      int len, d, csumOk;
      logic [7:0] b, sum;
      lens = '{1, 2, 3, 4, 4, 4, 5, 8, 32, 33};
      gaps = '{401, 401, 402, 600};
      for (int f = 0; f < nFrames; f++) begin
         len = lens[$urandom_range(0, 9)];
         csumOk = int'($urandom_range(0, 1));
         sum = 8'h00;
         for (int k = 0; k < len; k++) begin
            if (k > 0) begin
               case ($urandom_range(0, 9))
                  0: d = 400;
                  1: d = 399;
                  2: d = 1;
                  default: d = int'($urandom_range(2, 160));
               endcase
               addIdle(d - 1);
            end
            b = 8'($urandom);
            if (k == len - 1 && csumOk != 0) b = sum;
            addByte(b);
            sum = sum + b;
         end
         addIdle(gaps[$urandom_range(0, 3)] - 1);
      end
   endtask

   task automatic runStim(input string name);
      wr_t expW[$], obsW[$];
      done_t expD[$], obsD[$];
      int idx[$];
      logic [7:0] bv[$];
      int bLo[$], bHi[$];
      int n, s, e, len, dp, nMin;
      logic err, expBusy;
      logic [7:0] sum;
      addIdle(GAP + 20);
      n = sVld.size();
      for (int i = 0; i < n; i++)
         if (sVld[i]) begin
            idx.push_back(i);
            bv.push_back(sDat[i]);
         end
      // A frame is a run of bytes with at most GAP-1 silent cycles between neighbours
      s = 0;
      while (s < idx.size()) begin
         e = s;
         while (e + 1 < idx.size() && idx[e+1] - idx[e] <= GAP) e++;
         len = e - s + 1;
         for (int k = 0; k < len && k < DEPTH; k++)
            expW.push_back('{idx[s+k] + 1, k, int'(bv[s+k])});
         err = (len != BYTES) || (len > DEPTH);
`ifdef LCB_RX_CSUM_EN
         if (len < 2) err = 1'b1;
         else if (len <= DEPTH) begin
            sum = 8'h00;
            for (int k = 0; k < len - 1; k++) sum = sum + bv[s+k];
            if (sum != bv[e]) err = 1'b1;
         end
`else
         sum = 8'h00;
`endif
         expD.push_back('{idx[e] + GAP + 2, (len > DEPTH) ? DEPTH : len, int'(err)});
         bLo.push_back(idx[s] + 1);
         bHi.push_back(idx[e] + GAP);
         s = e + 1;
      end

      dp = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (oWE)   obsW.push_back('{i, int'(oWrAdr), int'(oWrData)});
         if (oDone) obsD.push_back('{i, int'(oLen), int'(oErr)});
         while (dp < expD.size() && expD[dp].cyc <= i) begin
            curLen = expD[dp].len;
            curErr = expD[dp].err;
            dp++;
         end
         checkVal({name, " oLen"}, 32'(oLen), 32'(curLen));
         checkVal({name, " oErr"}, 32'(oErr), 32'(curErr));
         expBusy = 1'b0;
         foreach (bLo[j]) if (i >= bLo[j] && i <= bHi[j]) expBusy = 1'b1;
         checkVal({name, " oBusy"}, 32'(oBusy), 32'(expBusy));
         iValid = sVld[i];
         iData  = sDat[i];
      end

      checkVal({name, " write count"}, obsW.size(), expW.size());
      nMin = (obsW.size() < expW.size()) ? obsW.size() : expW.size();
      for (int k = 0; k < nMin; k++) begin
         checkVal({name, " write cycle"}, obsW[k].cyc, expW[k].cyc);
         checkVal({name, " write adr"},   obsW[k].adr, expW[k].adr);
         checkVal({name, " write data"},  obsW[k].dat, expW[k].dat);
      end
      checkVal({name, " done count"}, obsD.size(), expD.size());
      nMin = (obsD.size() < expD.size()) ? obsD.size() : expD.size();
      for (int k = 0; k < nMin; k++) begin
         checkVal({name, " done cycle"}, obsD[k].cyc, expD[k].cyc);
         checkVal({name, " done len"},   obsD[k].len, expD[k].len);
         checkVal({name, " done err"},   obsD[k].err, expD[k].err);
      end
      sVld.delete();
      sDat.delete();
   endtask

   // Drive the queued stimulus with no reference (used ahead of a reset)
   task automatic driveOnly();
      for (int i = 0; i < sVld.size(); i++) begin
         @(negedge clk);
         iValid = sVld[i];
         iData  = sDat[i];
      end
      sVld.delete();
      sDat.delete();
   endtask

   task automatic checkAllZero(input string name);
      checkVal({name, " oWE"},     32'(oWE),     32'd0);
      checkVal({name, " oWrAdr"},  32'(oWrAdr),  32'd0);
      checkVal({name, " oWrData"}, 32'(oWrData), 32'd0);
      checkVal({name, " oDone"},   32'(oDone),   32'd0);
      checkVal({name, " oLen"},    32'(oLen),    32'd0);
      checkVal({name, " oErr"},    32'(oErr),    32'd0);
      checkVal({name, " oBusy"},   32'(oBusy),   32'd0);
   endtask

   initial begin
      #1;
      checkAllZero("reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Nominal 4-byte reply
      addIdle(5);
      addFrame(4, 170, 8'h11, 8'h11);
      runStim("basic");

      // Short frame followed by a good one
      addFrame(3, 170, 8'h21, 8'h01);
      addIdle(600);
      addFrame(4, 170, 8'h11, 8'h11);
      runStim("short");

      // Overflow: 34 bytes into a 32-byte buffer
      addFrame(34, 170, 8'h40, 8'h03);
      runStim("overflow");

      // 399 silent cycles keep the frame open
      addFrame(4, 170, 8'h11, 8'h11);
      addIdle(399);
      addFrame(4, 170, 8'h55, 8'h01);
      runStim("gap399");

      // 400 silent cycles close it; next byte lands on the close cycle
      addFrame(4, 170, 8'h11, 8'h11);
      addIdle(400);
      addFrame(4, 170, 8'h55, 8'h01);
      runStim("gap400");

      // Checksum patterns (good and bad trailing byte)
      addByte(8'h01); addIdle(169); addByte(8'h02); addIdle(169);
      addByte(8'h03); addIdle(169); addByte(8'h06); addIdle(700);
      addByte(8'h01); addIdle(169); addByte(8'h02); addIdle(169);
      addByte(8'h03); addIdle(169); addByte(8'h07);
      runStim("csum");

      // Reset in the middle of a frame discards it
      addIdle(3);
      addByte(8'hA5); addIdle(169); addByte(8'h5A); addIdle(20);
      driveOnly();
      @(negedge clk);
      checkVal("pre-reset oBusy",   32'(oBusy),   32'd1);
      checkVal("pre-reset oWrAdr",  32'(oWrAdr),  32'd1);
      checkVal("pre-reset oWrData", 32'(oWrData), 32'h5A);
      #2 rst = 1'b0;
      #1 checkAllZero("async reset");
      @(negedge clk);
      rst = 1'b1;
      curLen = 0;
      curErr = 0;
      addIdle(450);
      addFrame(4, 170, 8'hC1, 8'h01);
      runStim("after reset");

      // Randomized frame mixes
      for (int r = 0; r < 2; r++) begin
         addIdle(int'($urandom_range(1, 8)));
         addRandomFrames(6);
         runStim($sformatf("random%0d", r));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
